// File: rtl/sccb_master.sv
// sccb_master: write-only SCCB (I2C-like) master for camera register programming.
// Each accepted request sends a start condition, three bytes (device write ID, register
// address, register data) and then a stop condition. Every byte is followed by a ninth
// bit that is released and never sampled. Timing uses quarter-bit segments of Q clk
// cycles, where Q = CLK_FREQ / (4 * SCCB_FREQ).
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request one register write (taken only while ready = 1)
//   address  in   [7:0] camera register address, latched on accept
//   data     in   [7:0] register value, latched on accept
//   ready    out  1 when idle and able to accept start
//   SIOC_oe  out  1 pulls SIOC low, 0 releases it (external pull-up)
//   SIOD_oe  out  1 pulls SIOD low, 0 releases it (external pull-up)
//
// All outputs are registers. They are loaded from the next-state values, so a bus
// segment appears on the same edge on which the FSM enters it.
module sccb_master #(
    parameter int unsigned CLK_FREQ    = 25000000,
    parameter int unsigned SCCB_FREQ   = 100000,
    parameter logic [7:0]  CAMERA_ADDR = 8'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] address,
    input  logic [7:0] data,
    output logic       ready,
    output logic       SIOC_oe,
    output logic       SIOD_oe
);

    localparam int unsigned Q    = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int unsigned CntW = (Q > 1) ? $clog2(Q) : 1;

    if (Q < 1) begin : g_q_check
        $error("sccb_master: CLK_FREQ / (4 * SCCB_FREQ) must be at least 1");
    end

    localparam logic [CntW-1:0] CntLoad = CntW'(Q - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StTxByte,
        StStop
    } state_t;

    state_t          r_state, w_state_d;
    logic [1:0]      r_seg,   w_seg_d;    // segment within the current state or bit
    logic [3:0]      r_bit,   w_bit_d;    // 0..7 data bits, 8 = released ninth bit
    logic [1:0]      r_byte,  w_byte_d;   // 0 = device ID, 1 = address, 2 = data
    logic [CntW-1:0] r_cnt,   w_cnt_d;    // cycles left in the current segment
    logic [7:0]      r_addr,  w_addr_d;
    logic [7:0]      r_data,  w_data_d;
    logic            r_ready, w_ready_d;
    logic            r_sioc,  w_sioc_d;
    logic            r_siod,  w_siod_d;

    logic            w_accept;
    logic [7:0]      w_tx_byte;
    logic            w_tx_bit;

    assign w_accept = start & r_ready;

    // Next-state: segment sequencing and request latching.
    always_comb begin
        w_state_d = r_state;
        w_seg_d   = r_seg;
        w_bit_d   = r_bit;
        w_byte_d  = r_byte;
        w_cnt_d   = r_cnt;
        w_addr_d  = r_addr;
        w_data_d  = r_data;

        if (r_state == StIdle) begin
            if (w_accept) begin
                w_state_d = StStart;
                w_seg_d   = 2'd0;
                w_bit_d   = 4'd0;
                w_byte_d  = 2'd0;
                w_cnt_d   = CntLoad;
                w_addr_d  = address;
                w_data_d  = data;
            end
        end else if (r_cnt != '0) begin
            w_cnt_d = r_cnt - CntW'(1);
        end else begin
            w_cnt_d = CntLoad;
            case (r_state)
                StStart: begin
                    if (r_seg == 2'd0) begin
                        w_seg_d = 2'd1;
                    end else begin
                        w_state_d = StTxByte;
                        w_seg_d   = 2'd0;
                        w_bit_d   = 4'd0;
                        w_byte_d  = 2'd0;
                    end
                end
                StTxByte: begin
                    if (r_seg != 2'd3) begin
                        w_seg_d = r_seg + 2'd1;
                    end else begin
                        w_seg_d = 2'd0;
                        if (r_bit != 4'd8) begin
                            w_bit_d = r_bit + 4'd1;
                        end else begin
                            w_bit_d = 4'd0;
                            if (r_byte != 2'd2) begin
                                w_byte_d = r_byte + 2'd1;
                            end else begin
                                w_state_d = StStop;
                                w_byte_d  = 2'd0;
                            end
                        end
                    end
                end
                StStop: begin
                    if (r_seg != 2'd2) begin
                        w_seg_d = r_seg + 2'd1;
                    end else begin
                        w_state_d = StIdle;
                        w_seg_d   = 2'd0;
                        w_cnt_d   = '0;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_seg_d   = 2'd0;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    // Bus levels for the segment being entered.
    always_comb begin
        w_tx_byte = (w_byte_d == 2'd0) ? CAMERA_ADDR :
                    (w_byte_d == 2'd1) ? w_addr_d : w_data_d;
        // The ninth bit is sent as a 1, which leaves SIOD released for the slave's ack.
        w_tx_bit  = (w_bit_d == 4'd8) ? 1'b1 : w_tx_byte[3'd7 - w_bit_d[2:0]];

        w_ready_d = 1'b0;
        w_sioc_d  = 1'b0;
        w_siod_d  = 1'b0;
        case (w_state_d)
            StIdle: begin
                w_ready_d = 1'b1;
            end
            StStart: begin
                w_sioc_d = (w_seg_d != 2'd0);
                w_siod_d = 1'b1;
            end
            StTxByte: begin
                // SIOC low for segments 0-1, high for 2-3; SIOD only moves at segment 0.
                w_sioc_d = ~w_seg_d[1];
                w_siod_d = ~w_tx_bit;
            end
            StStop: begin
                w_sioc_d = (w_seg_d == 2'd0);
                w_siod_d = (w_seg_d != 2'd2);
            end
            default: begin
                w_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_seg   <= 2'd0;
            r_bit   <= 4'd0;
            r_byte  <= 2'd0;
            r_cnt   <= '0;
            r_addr  <= 8'd0;
            r_data  <= 8'd0;
            r_ready <= 1'b1;
            r_sioc  <= 1'b0;
            r_siod  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_seg   <= w_seg_d;
            r_bit   <= w_bit_d;
            r_byte  <= w_byte_d;
            r_cnt   <= w_cnt_d;
            r_addr  <= w_addr_d;
            r_data  <= w_data_d;
            r_ready <= w_ready_d;
            r_sioc  <= w_sioc_d;
            r_siod  <= w_siod_d;
        end
    end

    assign ready   = r_ready;
    assign SIOC_oe = r_sioc;
    assign SIOD_oe = r_siod;

endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master: scoreboard bench for sccb_master with Q = 4.
// Stimulus pushes the expected byte triple of each write into a queue. A bus monitor
// decodes start/stop conditions and the SIOD level on SIOC rising edges, then pops
// and compares one entry per frame. A ready monitor checks the busy window length.
module tb_sccb_master;

    localparam int unsigned CLK_FREQ  = 1600;
    localparam int unsigned SCCB_FREQ = 100;
    localparam int unsigned Q         = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int unsigned SEGS      = 2 + 27 * 4 + 3;
    localparam logic [7:0]  CAM       = 8'h42;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] address;
    logic [7:0] data;
    logic       ready;
    logic       SIOC_oe;
    logic       SIOD_oe;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [23:0] exp_q[$];

    sccb_master #(
        .CLK_FREQ   (CLK_FREQ),
        .SCCB_FREQ  (SCCB_FREQ),
        .CAMERA_ADDR(CAM)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .address(address),
        .data   (data),
        .ready  (ready),
        .SIOC_oe(SIOC_oe),
        .SIOD_oe(SIOD_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame scoring: 27 byte/ack bits plus the SIOC rise that opens the stop condition.
    task automatic score(input logic [63:0] rec, input int n);
        logic [23:0] got;
        logic [23:0] e;
        check("frame_bits", 32'(n), 32'd28);
        if (n == 28) begin
            got = {rec[27:20], rec[18:11], rec[9:2]};
            check("stop_sda_low", {31'd0, rec[0]}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got %06h expected none", got);
            end else begin
                e = exp_q.pop_front();
                check("frame_bytes", {8'd0, got}, {8'd0, e});
            end
        end
    endtask

    // Bus monitor, in open-drain levels: scl/sda high when released.
    initial begin : bus_mon
        logic        p_scl, p_sda, scl, sda, in_frame;
        logic [63:0] rec;
        int          n;
        p_scl    = 1'b1;
        p_sda    = 1'b1;
        in_frame = 1'b0;
        rec      = '0;
        n        = 0;
        forever begin
            @(negedge clk);
            scl = ~SIOC_oe;
            sda = ~SIOD_oe;
            if (!rst_n) begin
                in_frame = 1'b0;
            end else if (p_scl && scl && p_sda && !sda) begin
                in_frame = 1'b1;
                rec      = '0;
                n        = 0;
            end else if (p_scl && scl && !p_sda && sda) begin
                if (in_frame) score(rec, n);
                else check("stop_without_start", 32'd1, 32'd0);
                in_frame = 1'b0;
            end else if (!p_scl && scl && in_frame) begin
                rec = {rec[62:0], sda};
                n++;
            end
            p_scl = scl;
            p_sda = sda;
        end
    end

    // Busy window: ready low for SEGS*Q cycles per uninterrupted transfer.
    initial begin : ready_mon
        int   low_cnt;
        logic counting;
        low_cnt  = 0;
        counting = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                counting = 1'b0;
                low_cnt  = 0;
            end else if (!ready) begin
                counting = 1'b1;
                low_cnt++;
            end else if (counting) begin
                check("ready_low_cycles", 32'(low_cnt), 32'(SEGS * Q));
                counting = 1'b0;
                low_cnt  = 0;
            end
        end
    end

    // Called at a negedge with ready = 1; the following posedge accepts.
    task automatic issue(input logic [7:0] a, input logic [7:0] d);
        start   = 1'b1;
        address = a;
        data    = d;
        exp_q.push_back({CAM, a, d});
        @(negedge clk);
        start   = 1'b0;
        address = 8'($urandom);
        data    = 8'($urandom);
        check("accept_ready", {31'd0, ready}, 32'd0);
        check("accept_siod", {31'd0, SIOD_oe}, 32'd1);
        check("accept_sioc", {31'd0, SIOC_oe}, 32'd0);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("ready_within_bound", {31'd0, ready}, 32'd1);
    endtask

    initial begin : stim
        int   t0, t1;
        logic pr;
        rst_n   = 1'b0;
        start   = 1'b0;
        address = 8'd0;
        data    = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_sioc", {31'd0, SIOC_oe}, 32'd0);
        check("reset_siod", {31'd0, SIOD_oe}, 32'd0);

        // Start presented on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h12, 8'h80);
        wait_ready();

        // Busy-ignore: second request mid-transfer must not reach the bus.
        @(negedge clk);
        issue(8'($urandom), 8'($urandom));
        repeat (100) @(negedge clk);
        start   = 1'b1;
        address = 8'h3A;
        data    = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_ready();

        // Back-to-back with start held high.
        @(negedge clk);
        start   = 1'b1;
        address = 8'h11;
        data    = 8'h01;
        exp_q.push_back({CAM, 8'h11, 8'h01});
        exp_q.push_back({CAM, 8'h11, 8'h01});
        t0 = -1;
        t1 = -1;
        pr = 1'b1;
        for (int k = 0; k < 2000 && t1 < 0; k++) begin
            @(negedge clk);
            if (pr && !ready) begin
                if (t0 < 0) t0 = cyc;
                else t1 = cyc;
            end
            pr = ready;
        end
        start = 1'b0;
        check("b2b_spacing", 32'(t1 - t0), 32'(SEGS * Q + 1));
        wait_ready();

        // Random writes.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue(8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 30)) @(negedge clk);
            wait_ready();
        end

        // Reset during the register-address byte, then a fresh write.
        @(negedge clk);
        issue(8'($urandom), 8'($urandom));
        repeat ((2 + 9 * 4 + 4 * 4) * Q) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_sioc", {31'd0, SIOC_oe}, 32'd0);
        check("abort_siod", {31'd0, SIOD_oe}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'($urandom), 8'($urandom));
        wait_ready();

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
